i2s_tx_master: RTL and testbench
================================

Name: i2s_tx_master

Overview:
- I2S master transmitter: the opposite end of the chip's I2S input deserializer.
- Generates SCK and WS from the master clock and serializes 32-bit stereo words taken over a ready-to-send/ready-to-receive handshake.
- Used as the on-chip I2S source for loopback/BIST and as the driver for external codecs in master mode.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period (>=2); SCK period = 2*CLK_DIV clk.
- WORD_W, 16, bits per channel; frame = 2*WORD_W bits.

Ports:
- clk  input  1  master clock
- rst_n  input  1  asynchronous active-low reset
- tx_en  input  1  enable from register file
- tx_data  input  2*WORD_W  stereo word {left, right}, left in upper half
- tx_rts  input  1  upstream ready to send
- tx_rtr  output  1  block ready to receive
- trig_tx_underrun_clr  input  1  one-cycle pulse, clears ro_tx_underrun
- ro_tx_underrun  output  1  sticky underrun flag
- i2s_sck  output  1  serial clock
- i2s_ws  output  1  word select (0 = left, 1 = right)
- i2s_sd  output  1  serial data, MSB first

Behaviour:
- Reset (async, rst_n=0): all outputs 0. div_cnt=0, bit_cnt=31, hold_valid=0, armed=0, shift=0.
- Disabled (tx_en=0): synchronous clear to the reset state, except ro_tx_underrun, which is retained.
- SCK generation:
  - div_cnt counts 0..CLK_DIV-1 while enabled.
  - At terminal count, SCK toggles and div_cnt wraps.
  - First toggle after enable is a rising edge, CLK_DIV cycles after tx_en rises.
- Falling-edge update (the clk cycle SCK goes 1->0), all in that same cycle:
  - bit_cnt = (bit_cnt+1) mod 32.
  - sd = frame bit [31-bit_cnt].
  - ws = 1 when new bit_cnt is in 15..30, else 0. WS therefore leads the channel MSB by one SCK.
- Receivers sample on the SCK rising edge; sd/ws are stable for one full SCK period.
- Frame load: on the falling edge where bit_cnt wraps 31->0:
  - If hold_valid: shift <= hold, hold_valid <= 0, armed <= 1.
  - Else: shift <= 0. If armed, ro_tx_underrun <= 1.
  - Bit 31 of the loaded frame is driven on i2s_sd in that same cycle.
- No underrun is flagged before the first successful load after enable.
- Handshake:
  - tx_rtr = tx_en & ~hold_valid (combinational from registers).
  - A transfer happens in a cycle where tx_rts & tx_rtr. hold <= tx_data, hold_valid <= 1 next cycle.
  - tx_data is ignored when tx_rtr=0.
- Transfer and frame load in the same cycle: the load consumes the old hold contents (hold_valid was 0, so no load occurs). The new word sits in hold for the next frame; no underrun is suppressed.
- Underrun flag:
  - Sticky; cleared by trig_tx_underrun_clr.
  - A set and a clear in the same cycle: set wins.
- Latency: a word accepted while hold is empty appears at the next frame boundary; worst case 64*CLK_DIV clk.
- Throughput: one word per frame.
- Reset mid-frame: outputs go to 0 immediately; after rst_n rises, no partial frame resumes.

Test Plan:
- CLK_DIV=2, enable, tx_rts held 1 with tx_data=32'hA5A5_0F0F:
  - SCK period is 4 clk.
  - First falling edge at clk 4 after enable, with sd=1 (bit 31) and ws=0.
  - ws rises at bit 15 (one SCK before right MSB).
  - The captured frame equals A5A50F0F; ro_tx_underrun stays 0.
- Back-to-back words 32'h8000_0001 then 32'h7FFF_FFFE:
  - tx_rtr is low except one cycle per frame.
  - Frames are contiguous (128 clk apart).
  - Bits match, with no gap in SCK.
- Underrun: send one word, then drop tx_rts:
  - Next frame transmits all zeros.
  - ro_tx_underrun=1 at that frame boundary.
  - A trig_tx_underrun_clr pulse clears it.
  - Clear coincident with a new underrun keeps it at 1.
- Enable with no data ever supplied: SCK and WS run, sd=0, ro_tx_underrun stays 0 (not armed).
- tx_en dropped mid-frame (bit 10):
  - Next cycle sck=ws=sd=0 and tx_rtr=0.
  - Re-enable restarts with the first falling edge after 2*CLK_DIV clk, loading a fresh frame.
- rst_n asserted mid-frame: all outputs 0 asynchronously (before the next clk edge); ro_tx_underrun=0.

Source files
------------

// File: rtl/i2s_tx_master.sv
// I2S master transmitter. Divides clk down to SCK, updates WS/SD on SCK
// falling edges so receivers can sample on rising edges, and takes one
// stereo word per frame from upstream over an RTS/RTR handshake. A word is
// parked in a one-deep hold register until the next frame boundary.
module i2s_tx_master #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic [2*WORD_W-1:0] tx_data,
  input  logic                tx_rts,
  output logic                tx_rtr,
  input  logic                trig_tx_underrun_clr,
  output logic                ro_tx_underrun,
  output logic                i2s_sck,
  output logic                i2s_ws,
  output logic                i2s_sd
);

  localparam int FRAME_W = 2 * WORD_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  // WS switches one SCK ahead of each channel MSB.
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_W - 2);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sck_q, sck_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               armed_q, armed_d;
  logic               underrun_q, underrun_d;

  logic               div_tc;
  logic               sck_fall;
  logic               bit_wrap;
  logic               xfer;
  logic               set_underrun;
  logic [BIT_W-1:0]   bit_nxt;
  logic [FRAME_W-1:0] frame;

  assign tx_rtr         = tx_en & ~hold_valid_q;
  assign ro_tx_underrun = underrun_q;
  assign i2s_sck        = sck_q;
  assign i2s_ws         = ws_q;
  assign i2s_sd         = sd_q;

  // Next-state: SCK divider, falling-edge bit update, frame load, handshake, sticky flag.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    sck_d        = sck_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    armed_d      = armed_q;
    set_underrun = 1'b0;
    bit_nxt      = bit_cnt_q;
    frame        = shift_q;

    div_tc   = (div_cnt_q == DIV_TC);
    sck_fall = tx_en & div_tc & sck_q;
    bit_wrap = sck_fall & (bit_cnt_q == BIT_LAST);
    xfer     = tx_rts & tx_rtr;

    if (!tx_en) begin
      // Disabled: everything but the underrun flag returns to its reset value,
      // so re-enabling always starts on a fresh frame.
      div_cnt_d    = '0;
      sck_d        = 1'b0;
      ws_d         = 1'b0;
      sd_d         = 1'b0;
      bit_cnt_d    = BIT_LAST;
      shift_d      = '0;
      hold_d       = '0;
      hold_valid_d = 1'b0;
      armed_d      = 1'b0;
    end else begin
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      if (div_tc) begin
        sck_d = ~sck_q;
      end

      if (sck_fall) begin
        bit_nxt   = bit_wrap ? '0 : bit_cnt_q + 1'b1;
        bit_cnt_d = bit_nxt;
        if (bit_wrap) begin
          if (hold_valid_q) begin
            frame        = hold_q;
            hold_valid_d = 1'b0;
            armed_d      = 1'b1;
          end else begin
            // Nothing queued: send silence; only an underrun once data has flowed.
            frame        = '0;
            set_underrun = armed_q;
          end
          shift_d = frame;
        end
        sd_d = frame[BIT_LAST - bit_nxt];
        ws_d = (bit_nxt >= WS_FIRST) && (bit_nxt <= WS_LAST);
      end

      // xfer implies hold is empty, so it never collides with a load above.
      if (xfer) begin
        hold_d       = tx_data;
        hold_valid_d = 1'b1;
      end
    end

    // Set beats a simultaneous clear so an underrun is never lost.
    if (set_underrun) begin
      underrun_d = 1'b1;
    end else if (trig_tx_underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      bit_cnt_q    <= BIT_LAST;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sck_q        <= sck_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      armed_q      <= armed_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: per-cycle comparison of SCK/WS/SD/RTR/underrun
// against an arithmetic timing model, plus an I2S receiver that decodes frames.
module tb_i2s_tx_master;

  localparam int CD = 2;        // clk per SCK half-period
  localparam int P  = 2 * CD;   // clk per SCK period; first falling edge offset
  localparam int F  = 64 * CD;  // clk per frame

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_en = 1'b0;
  logic [31:0] tx_data = 32'h0;
  logic        tx_rts = 1'b0;
  logic        trig = 1'b0;
  logic        tx_rtr;
  logic        ro_tx_underrun;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic und_model = 1'b0;

  logic [31:0] words_q[$];
  logic [31:0] cap_q[$];
  int          cap_t[$];

  i2s_tx_master #(.CLK_DIV(CD), .WORD_W(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .tx_en                (tx_en),
    .tx_data              (tx_data),
    .tx_rts               (tx_rts),
    .tx_rtr               (tx_rtr),
    .trig_tx_underrun_clr (trig),
    .ro_tx_underrun       (ro_tx_underrun),
    .i2s_sck              (i2s_sck),
    .i2s_ws               (i2s_ws),
    .i2s_sd               (i2s_sd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: sample on SCK rising edges; a frame ends on the first WS=0 after WS=1.
  logic        mon_sck_prev = 1'b0;
  logic        mon_ws_prev = 1'b0;
  logic [31:0] mon_sh = 32'h0;
  always @(posedge clk) begin
    #2;
    if (!rst_n || !tx_en) begin
      mon_sck_prev = 1'b0;
      mon_ws_prev  = 1'b0;
      mon_sh       = 32'h0;
    end else begin
      if (i2s_sck && !mon_sck_prev) begin
        mon_sh = {mon_sh[30:0], i2s_sd};
        if (mon_ws_prev && !i2s_ws) begin
          cap_q.push_back(mon_sh);
          cap_t.push_back(cyc);
        end
        mon_ws_prev = i2s_ws;
      end
      mon_sck_prev = i2s_sck;
    end
  end

  // Enable, feed words_q whenever RTR allows, compare every cycle, then disable
  // (or assert reset at rst_at) and check the idle state.
  task automatic run_stream(input string name, input int ncyc, input int clr1,
                            input int clr2, input int rst_at);
    int n, idx, nfail, p, b, f;
    logic rtr_s, set_e, clr_e, e_sck, e_ws, e_sd, e_rtr;
    logic [31:0] fw;
    logic [4:0] got, expv;
    n = words_q.size();
    idx = 0;
    nfail = 0;
    cap_q.delete();
    cap_t.delete();
    @(negedge clk);
    tx_en = 1'b1;
    trig  = 1'b0;
    if (n > 0) begin
      tx_rts = 1'b1; tx_data = words_q[0]; idx = 1;
    end else begin
      tx_rts = 1'b0; tx_data = $urandom;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      rtr_s = tx_rtr;
      e_sck = ((k / CD) % 2) == 1;
      if (k >= P) begin
        p = k / P - 1;
        b = p % 32;
        f = p / 32;
        fw = (f < n) ? words_q[f] : 32'h0;
        e_sd = fw[31 - b];
        e_ws = (b >= 15) && (b <= 30);
      end else begin
        e_sd = 1'b0;
        e_ws = 1'b0;
      end
      e_rtr = (k >= P + F * (n - 1)) || ((k >= P) && (((k - P) % F) == 0));
      got  = {i2s_sck, i2s_ws, i2s_sd, tx_rtr, ro_tx_underrun};
      expv = {e_sck, e_ws, e_sd, e_rtr, und_model};
      checks++;
      if (got !== expv) begin
        errors++;
        if (nfail < 8)
          $display("FAIL %s k=%0d {sck,ws,sd,rtr,und} got %b exp %b", name, k, got, expv);
        nfail++;
      end
      // Underrun rule for the coming edge: frame boundary m >= n with data having flowed.
      set_e = (n >= 1) && (k + 1 >= P) && (((k + 1 - P) % F) == 0) && (((k + 1 - P) / F) >= n);
      clr_e = (k == clr1) || (k == clr2);
      if (set_e) und_model = 1'b1;
      else if (clr_e) und_model = 1'b0;
      trig = clr_e;
      if (rtr_s && idx < n) begin
        tx_rts = 1'b1; tx_data = words_q[idx]; idx++;
      end else begin
        tx_rts = (idx < n); tx_data = $urandom;
      end
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({i2s_sck, i2s_ws, i2s_sd, ro_tx_underrun} !== 4'b0000)
          $display("FAIL %s async_reset {sck,ws,sd,und} got %b exp 0000", name,
                   {i2s_sck, i2s_ws, i2s_sd, ro_tx_underrun});
        if ({i2s_sck, i2s_ws, i2s_sd, ro_tx_underrun} !== 4'b0000) errors++;
        und_model = 1'b0;
        break;
      end
    end
    if (!rst_n) begin
      @(negedge clk);
      tx_en = 1'b0; tx_rts = 1'b0; trig = 1'b0; rst_n = 1'b1;
    end else begin
      @(negedge clk);
      tx_en = 1'b0; tx_rts = 1'b0; trig = 1'b0;
      @(negedge clk);
      got  = {i2s_sck, i2s_ws, i2s_sd, tx_rtr, ro_tx_underrun};
      expv = {4'b0000, und_model};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s disabled {sck,ws,sd,rtr,und} got %b exp %b", name, got, expv);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2s_sck, i2s_ws, i2s_sd, tx_rtr, ro_tx_underrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset outputs got %b exp 00000",
               {i2s_sck, i2s_ws, i2s_sd, tx_rtr, ro_tx_underrun});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({i2s_sck, i2s_ws, i2s_sd, tx_rtr, ro_tx_underrun} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b exp 00000",
               {i2s_sck, i2s_ws, i2s_sd, tx_rtr, ro_tx_underrun});
    end
  endtask

  task automatic test_basic();
    words_q = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    run_stream("basic", 390, -1, -1, -1);
    checks++;
    if (cap_q.size() != 3) begin
      errors++;
      $display("FAIL basic_nframes got %0d exp 3", cap_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap_q[i] !== 32'hA5A5_0F0F) begin
          errors++;
          $display("FAIL basic_frame%0d got %h exp a5a50f0f", i, cap_q[i]);
        end
      end
      checks++;
      if (cap_t[2] - cap_t[1] != F) begin
        errors++;
        $display("FAIL basic_spacing got %0d exp %0d", cap_t[2] - cap_t[1], F);
      end
    end
  endtask

  task automatic test_back_to_back();
    words_q = '{32'h8000_0001, 32'h7FFF_FFFE};
    run_stream("b2b", 258, -1, -1, -1);
    checks++;
    if (cap_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_nframes got %0d exp 2", cap_q.size());
    end else begin
      checks++;
      if (cap_q[0] !== 32'h8000_0001 || cap_q[1] !== 32'h7FFF_FFFE) begin
        errors++;
        $display("FAIL b2b_frames got %h %h exp 80000001 7ffffffe", cap_q[0], cap_q[1]);
      end
      checks++;
      if (cap_t[1] - cap_t[0] != F) begin
        errors++;
        $display("FAIL b2b_spacing got %0d exp %0d", cap_t[1] - cap_t[0], F);
      end
    end
  endtask

  task automatic test_nodata();
    words_q = {};
    run_stream("nodata", 300, -1, -1, -1);
    checks++;
    if (cap_q.size() != 2 || cap_q[0] !== 32'h0) begin
      errors++;
      $display("FAIL nodata_frames got n=%0d exp n=2 of zero", cap_q.size());
    end
  endtask

  task automatic test_underrun();
    logic [31:0] w;
    w = $urandom;
    words_q = '{w};
    // Clear at 200, then a clear coincident with the next underrun at 259.
    run_stream("underrun", 300, 200, 2 * F + P - 1, -1);
    checks++;
    if (cap_q.size() != 2 || cap_q[0] !== w || cap_q[1] !== 32'h0) begin
      errors++;
      $display("FAIL underrun_frames got n=%0d exp word %h then 0", cap_q.size(), w);
    end
  endtask

  task automatic test_disable_mid();
    words_q = '{$urandom, $urandom};
    run_stream("disable_bit10", 11 * P, -1, -1, -1);
    words_q = '{$urandom};
    run_stream("reenable", 150, 10, -1, -1);
  endtask

  task automatic test_reset_mid();
    words_q = '{$urandom};
    run_stream("reset_mid", 300, -1, -1, 180);
    words_q = {};
    run_stream("after_reset", 100, -1, -1, -1);
  endtask

  task automatic test_random();
    int n, ncyc, c1;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 3);
      ncyc = $urandom_range(40, 450);
      c1 = $urandom_range(1, ncyc);
      words_q = {};
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      run_stream("random", ncyc, c1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_nodata();
    test_underrun();
    test_disable_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
